conditional_mux: RTL and testbench

Parametrised N-way conditional select unit for the Versat datapath; generalises the two-way selector unit. Per cycle, a selector word picks one of `N_IN` data channels (or a default value) and presents it at `out0` after a configurable pipeline latency. Adds run/done sequencing: a start delay, a bounded sample count, an out-of-range policy and a hold mode, so it plugs into accelerator configurations that need timed, counted selection.

---
 rtl/conditional_mux_pkg.sv | 21 ++
 rtl/conditional_mux_pipe.sv | 45 ++++
 rtl/conditional_mux.sv | 133 +++++++++++++
 tb/tb_conditional_mux.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conditional_mux_pkg.sv
// Shared state and mode codes for the conditional select unit.
// No logic of its own; imported by the top and pipeline.
// Not applicable: declarations only.
package conditional_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_INDEX  = 2'd0;
    localparam logic [1:0] MODE_BINARY = 2'd1;
    localparam logic [1:0] MODE_HOLD   = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    // Drain counter only has to cover LATENCY up to 8.
    localparam int DRAIN_W = 4;

endpackage

// File: rtl/conditional_mux_pipe.sv
// Data+valid delay line whose data stages only load behind a valid bit.
// Latency: DEPTH cycles from in_valid/in_data to out_valid/out_data.
// Backpressure: none; en low freezes every stage in place.
module conditional_mux_pipe #(
    parameter int W     = 32,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [W-1:0]     dat [DEPTH];

    // Data only moves with its valid bit, so the last stage doubles as the
    // hold register for the unit output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
            end
        end else if (en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/conditional_mux.sv
// N-way conditional select with start delay, sample count, range policy and hold mode.
// Latency: LATENCY cycles from a sampled selector to out0/out_valid.
// Backpressure: none; running low freezes all state and masks out_valid.
module conditional_mux
    import conditional_mux_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int N_IN    = 4,
    parameter int LATENCY = 1,
    parameter int DELAY_W = 32,
    parameter int LEN_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     running,
    input  logic                     run,
    output logic                     done,
    input  logic [DATA_W-1:0]        in0,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic [DELAY_W-1:0]       delay0,
    input  logic [LEN_W-1:0]         length,
    input  logic [1:0]               mode,
    input  logic [DATA_W-1:0]        default_val,
    output logic [DATA_W-1:0]        out0,
    output logic                     out_valid
);

    localparam int SEL_W          = $clog2(N_IN);
    localparam int versat_latency = LATENCY;

    state_t               state;
    logic [DELAY_W-1:0]   dly_cnt;
    logic [LEN_W-1:0]     len_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [1:0]           mode_q;
    logic [DATA_W-1:0]    default_q;
    logic [DATA_W-1:0]    last_q;

    logic [SEL_W-1:0]     sel;
    logic                 in_range;
    logic [DATA_W-1:0]    chosen;
    logic [DATA_W-1:0]    sample;
    logic                 take;
    logic                 pipe_valid;

    always_comb begin
        sel      = in0[SEL_W-1:0];
        in_range = in0 < DATA_W'(N_IN);
        chosen   = in_data[int'(sel)*DATA_W +: DATA_W];
        sample   = chosen;
        case (mode_q)
            MODE_BINARY: sample = in0[0] ? in_data[0 +: DATA_W] : in_data[DATA_W +: DATA_W];
            // Samples leave the pipe in order, so the last value sent in is
            // the last value out0 will have shown by the time this one emerges.
            MODE_HOLD:   if (!in_range) sample = last_q;
            MODE_INDEX,
            MODE_RSVD:   if (!in_range) sample = default_q;
        endcase
        take = running && (state == ST_ACTIVE) && (len_cnt != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            dly_cnt   <= '0;
            len_cnt   <= '0;
            drain_cnt <= '0;
            mode_q    <= MODE_INDEX;
            default_q <= '0;
            last_q    <= '0;
        end else if (running) begin
            if (take) begin
                last_q <= sample;
            end
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        mode_q    <= mode;
                        default_q <= default_val;
                        len_cnt   <= length;
                        if (delay0 != '0) begin
                            dly_cnt <= delay0 - DELAY_W'(1);
                            state   <= ST_DELAY;
                        end else begin
                            state   <= ST_ACTIVE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt == '0) begin
                        state <= ST_ACTIVE;
                    end else begin
                        dly_cnt <= dly_cnt - DELAY_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (len_cnt != '0) begin
                        len_cnt <= len_cnt - LEN_W'(1);
                    end
                    if (len_cnt <= LEN_W'(1)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_W'(versat_latency - 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    conditional_mux_pipe #(
        .W     (DATA_W),
        .DEPTH (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (running),
        .in_valid  (take),
        .in_data   (sample),
        .out_valid (pipe_valid),
        .out_data  (out0)
    );

    assign out_valid = pipe_valid & running;
    assign done      = (state == ST_IDLE);

endmodule

// File: tb/tb_conditional_mux.sv
// Drives two instances (LATENCY 1 and 3) with shared stimulus and compares
// every cycle against a run-timeline reference model.
module tb_conditional_mux;

    logic         clk = 1'b0;
    logic         rst, running, run;
    logic [31:0]  in0, default_val, delay0;
    logic [127:0] in_data;
    logic [15:0]  length;
    logic [1:0]   mode;
    logic         done1, done3, ov1, ov3;
    logic [31:0]  out01, out03;

    always #5 clk = ~clk;

    conditional_mux #(.DATA_W(32), .N_IN(4), .LATENCY(1), .DELAY_W(32), .LEN_W(16)) u_lat1 (
        .clk(clk), .rst(rst), .running(running), .run(run), .done(done1),
        .in0(in0), .in_data(in_data), .delay0(delay0), .length(length),
        .mode(mode), .default_val(default_val), .out0(out01), .out_valid(ov1)
    );

    conditional_mux #(.DATA_W(32), .N_IN(4), .LATENCY(3), .DELAY_W(32), .LEN_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .running(running), .run(run), .done(done3),
        .in0(in0), .in_data(in_data), .delay0(delay0), .length(length),
        .mode(mode), .default_val(default_val), .out0(out03), .out_valid(ov3)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ch [4];
    logic [31:0] sels [16];
    bit          rand_ch = 0;
    int          rc1, rc3;

    // Reference model: per instance, count running cycles since the run
    // was accepted and derive sample/emit/done points from that count.
    bit          m_act [2];
    int          m_j   [2];
    int          m_dly [2];
    int          m_len [2];
    logic [1:0]  m_mode[2];
    logic [31:0] m_dflt[2];
    logic [31:0] m_out [2];
    bit          m_vld [2];
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit 32 set means "repeat whatever out0 shows when this emerges".
    function automatic logic [32:0] ref_pick(input logic [1:0] md, input logic [31:0] s,
                                             input logic [31:0] dflt);
        if (md == 2'd1) return {1'b0, (s[0] ? ch[0] : ch[1])};
        if (s < 32'd4) return {1'b0, ch[s[1:0]]};
        if (md == 2'd2) return {1'b1, 32'h0};
        return {1'b0, dflt};
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0;
            m_vld[d] = 0;
            m_out[d] = '0;
        end
        q0.delete();
        q1.delete();
    endfunction

    function automatic void model_update();
        logic [32:0] e;
        int lat;
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 1 : 3;
            if (!running) continue;
            if (!m_act[d]) begin
                m_vld[d] = 0;
                if (run) begin
                    m_act[d]  = 1;
                    m_j[d]    = 0;
                    m_dly[d]  = int'(delay0);
                    m_len[d]  = int'(length);
                    m_mode[d] = mode;
                    m_dflt[d] = default_val;
                end
            end else begin
                m_j[d]++;
                if (m_j[d] > m_dly[d] && m_j[d] <= m_dly[d] + m_len[d]) begin
                    e = ref_pick(m_mode[d], in0, m_dflt[d]);
                    if (d == 0) q0.push_back(e); else q1.push_back(e);
                end
                m_vld[d] = 0;
                if (m_j[d] >= m_dly[d] + lat && m_j[d] <= m_dly[d] + m_len[d] + lat - 1) begin
                    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                    m_vld[d] = 1;
                    if (!e[32]) m_out[d] = e[31:0];
                end
                if (m_j[d] == m_dly[d] + m_len[d] + lat) m_act[d] = 0;
            end
        end
    endfunction

    task automatic tick();
        in_data = {ch[3], ch[2], ch[1], ch[0]};
        #1;
        chk("done_l1",  done1, !m_act[0]);
        chk("valid_l1", ov1,   m_vld[0] & running);
        chk("out0_l1",  out01, m_out[0]);
        chk("done_l3",  done3, !m_act[1]);
        chk("valid_l3", ov3,   m_vld[1] & running);
        chk("out0_l3",  out03, m_out[1]);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        chk("rst_done_l1",  done1, 1'b1);
        chk("rst_done_l3",  done3, 1'b1);
        chk("rst_out0_l1",  out01, 32'h0);
        chk("rst_out0_l3",  out03, 32'h0);
        chk("rst_valid_l1", ov1,   1'b0);
        chk("rst_valid_l3", ov3,   1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_seq(input int dly, input int len, input logic [1:0] md,
                           input logic [31:0] dflt, input int stall_at, input int stall_n,
                           input int rerun_at, input int rst_at);
        int  c;
        int  left;
        bit  fin;
        c    = 0;
        left = stall_n;
        fin  = 0;
        rc1  = -1;
        rc3  = -1;
        run = 1'b1; running = 1'b1; delay0 = dly; length = 16'(len);
        mode = md; default_val = dflt; in0 = $urandom;
        tick();
        // Scramble config so a late re-latch would show up.
        run = 1'b0; delay0 = $urandom; length = 16'($urandom);
        mode = 2'($urandom); default_val = $urandom;
        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            if (left > 0 && c == stall_at) begin
                running = 1'b0;
                left--;
            end else begin
                running = 1'b1;
                c++;
            end
            if (running && c > dly && c <= dly + len) in0 = sels[c-dly-1];
            else in0 = $urandom;
            if (rand_ch) for (int k = 0; k < 4; k++) ch[k] = $urandom;
            run = (cyc == rerun_at);
            if (cyc == rst_at) begin
                mid_reset();
                run = 1'b0;
                running = 1'b1;
                return;
            end
            tick();
            if (done1 && rc1 < 0) rc1 = cyc + 1;
            if (done3 && rc3 < 0) rc3 = cyc + 1;
            fin = done1 && done3 && !m_act[0] && !m_act[1];
        end
        run = 1'b0;
        running = 1'b1;
        chk("run_complete", fin, 1'b1);
    endtask

    initial begin
        rst = 1'b1; running = 1'b1; run = 1'b0; in0 = '0; default_val = '0;
        delay0 = '0; length = '0; mode = '0;
        for (int k = 0; k < 4; k++) ch[k] = 32'h10 + k;
        in_data = {ch[3], ch[2], ch[1], ch[0]};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done_l1",  done1, 1'b1);
        chk("reset_out0_l1",  out01, 32'h0);
        chk("reset_valid_l1", ov1,   1'b0);
        chk("reset_done_l3",  done3, 1'b1);
        chk("reset_out0_l3",  out03, 32'h0);
        chk("reset_valid_l3", ov3,   1'b0);
        rst = 1'b0;
        model_reset();
        tick();

        // Four in-range selections, channel k = 0x10+k.
        sels[0] = 0; sels[1] = 1; sels[2] = 2; sels[3] = 3;
        run_seq(0, 4, 2'd0, 32'h0, -1, 0, -1, -1);
        chk("t1_done_cycle_l1", rc1, 6);
        chk("t1_last_out0_l1", out01, 32'h13);
        tick();

        // Out-of-range selectors, including nonzero upper bits.
        sels[0] = 5; sels[1] = 32'h0100_0001;
        run_seq(0, 2, 2'd0, 32'hDEAD, -1, 0, -1, -1);
        chk("t2_default_l1", out01, 32'hDEAD);
        chk("t2_default_l3", out03, 32'hDEAD);

        // Hold mode repeats the previous emitted value.
        ch[2] = 32'h22;
        sels[0] = 2; sels[1] = 7;
        run_seq(0, 2, 2'd2, 32'hBAD0, -1, 0, -1, -1);
        chk("t3_hold_l1", out01, 32'h22);
        chk("t3_hold_l3", out03, 32'h22);

        // Binary mode on bit 0 only.
        ch[0] = 32'hA; ch[1] = 32'hB;
        sels[0] = 3; sels[1] = 2;
        run_seq(0, 2, 2'd1, 32'h0, -1, 0, -1, -1);
        chk("t4_binary_l1", out01, 32'hB);
        chk("t4_binary_l3", out03, 32'hB);

        // Start delay plus a two-cycle stall after the first sample.
        sels[0] = 1; sels[1] = 3;
        run_seq(3, 2, 2'd0, 32'h0, 4, 2, -1, -1);
        chk("t5_run_cycles_l3", rc3, 11);
        chk("t5_run_cycles_l1", rc1, 9);

        // Second run during DELAY ignored, then reset mid-ACTIVE.
        for (int i = 0; i < 4; i++) sels[i] = i;
        run_seq(5, 4, 2'd0, 32'h0, -1, 0, 2, 9);
        tick();

        rand_ch = 1;
        for (int r = 0; r < 40; r++) begin
            int dly, len;
            dly = $urandom_range(0, 4);
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++)
                sels[i] = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(0, 5)) : $urandom;
            run_seq(dly, len, 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, dly + len + 2), $urandom_range(0, 3), -1, -1);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
